// File: rtl/sd_stream_ctrl.sv
// sd_stream_ctrl: stream-fed zero-order-hold sequencer for a sigma-delta modulator.
// Optional fade-out on stop is built when SD_STREAM_CTRL_RAMP_EN is defined.
module sd_stream_ctrl #(
    parameter int WIDTH   = 16,
    parameter int OSR     = 64,
    parameter int CLK_DIV = 1,
    parameter int UCNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [WIDTH-1:0] mod_in,
    output logic                    mod_en,
    output logic                    mod_rst,
    output logic                    underflow,
    output logic [UCNT_W-1:0]       underflow_cnt,
    output logic                    busy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

`ifdef SD_STREAM_CTRL_RAMP_EN
    typedef enum logic [2:0] {IDLE, WAIT, RUN, RAMP, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, RUN, STOP} state_t;
`endif

    state_t                  state;
    logic [DW-1:0]           div;
    logic [PW-1:0]           ph;
    logic signed [WIDTH-1:0] nxt;
    logic                    nxt_full;
    logic                    active;
    logic                    tick;
    logic                    boundary;
    logic                    accept;

`ifdef SD_STREAM_CTRL_RAMP_EN
    assign active = (state == RUN) || (state == RAMP);
`else
    assign active = (state == RUN);
`endif

    assign tick     = active && (div == DW'(CLK_DIV - 1));
    assign boundary = tick && (ph == PW'(OSR - 1));
    assign s_ready  = !nxt_full && ((state == WAIT) || (state == RUN));
    assign accept   = s_valid && s_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            div           <= '0;
            ph            <= '0;
            nxt           <= '0;
            nxt_full      <= 1'b0;
            mod_in        <= '0;
            mod_en        <= 1'b0;
            mod_rst       <= 1'b1;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            mod_en    <= tick;
            underflow <= 1'b0;
            if (active) begin
                div <= tick ? '0 : div + 1'b1;
                if (tick)
                    ph <= boundary ? '0 : ph + 1'b1;
            end
            if (accept) begin
                nxt      <= s_data;
                nxt_full <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    mod_rst <= 1'b1;
                    mod_in  <= '0;
                    div     <= '0;
                    ph      <= '0;
                    if (run)
                        state <= WAIT;
                end
                WAIT: begin
                    if (!run) begin
                        nxt_full <= 1'b0;
                        state    <= IDLE;
                    end else if (nxt_full) begin
                        mod_in   <= nxt;
                        nxt_full <= 1'b0;
                        mod_rst  <= 1'b0;
                        div      <= '0;
                        ph       <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        if (!run) begin
                            nxt_full <= 1'b0;
`ifdef SD_STREAM_CTRL_RAMP_EN
                            mod_in   <= mod_in >>> 1;
                            state    <= RAMP;
`else
                            state    <= STOP;
`endif
                        end else if (nxt_full) begin
                            mod_in   <= nxt;
                            nxt_full <= 1'b0;
                        end else begin
                            underflow <= 1'b1;
                            if (underflow_cnt != '1)
                                underflow_cnt <= underflow_cnt + 1'b1;
                        end
                    end
                end
`ifdef SD_STREAM_CTRL_RAMP_EN
                // Halve once per period; 0 and -1 are the fixed points of >>>.
                RAMP: begin
                    if (boundary) begin
                        if (mod_in == '0 || mod_in == '1)
                            state <= STOP;
                        else
                            mod_in <= mod_in >>> 1;
                    end
                end
`endif
                STOP: begin
                    mod_in   <= '0;
                    mod_rst  <= 1'b1;
                    nxt_full <= 1'b0;
                    div      <= '0;
                    ph       <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_stream_ctrl.sv
// tb_sd_stream_ctrl: directed checks of sd_stream_ctrl with OSR=4, CLK_DIV=2.
// Ramp checks are compiled only when SD_STREAM_CTRL_RAMP_EN is defined.
module tb_sd_stream_ctrl;

    localparam int W   = 16;
    localparam int OSR = 4;
    localparam int DIV = 2;
    localparam int UW  = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                run = 1'b0;
    logic signed [W-1:0] s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [W-1:0] mod_in;
    logic                mod_en;
    logic                mod_rst;
    logic                underflow;
    logic [UW-1:0]       underflow_cnt;
    logic                busy;

    int n_run  = 0;
    int n_fail = 0;

    sd_stream_ctrl #(
        .WIDTH(W), .OSR(OSR), .CLK_DIV(DIV), .UCNT_W(UW)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mod_in(mod_in), .mod_en(mod_en), .mod_rst(mod_rst),
        .underflow(underflow), .underflow_cnt(underflow_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint want);
        n_run++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // mod_in history: each entry is a past value, its hold in clks and its mod_en count
    bit                  mon_on = 0;
    logic signed [W-1:0] prev;
    int                  hold;
    int                  pulses;
    logic signed [W-1:0] vals[$];
    int                  holds[$];
    int                  pls[$];

    always @(negedge clk) begin
        if (mon_on) begin
            if (mod_in !== prev) begin
                vals.push_back(prev);
                holds.push_back(hold);
                pls.push_back(pulses);
                prev   = mod_in;
                hold   = 0;
                pulses = 0;
            end
            hold++;
            if (mod_en)
                pulses++;
        end
    end

    task automatic mon_start();
        vals.delete();
        holds.delete();
        pls.delete();
        prev   = mod_in;
        hold   = 0;
        pulses = 0;
        mon_on = 1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        run = 1'b0;
        s_valid = 1'b0;
        mon_on = 0;
        cyc(2);
        rst = 1'b0;
    endtask

    // leaves s_valid high so back-to-back sends model a continuous source
    task automatic send(input logic signed [W-1:0] d);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 40) begin
            cyc(1);
            n++;
        end
        if (!s_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            cyc(1);
            check("ready_drop", s_ready, 0);
        end
    endtask

    task automatic wait_mod(input logic signed [W-1:0] v);
        int n = 0;
        while (mod_in !== v && n < 100) begin
            cyc(1);
            n++;
        end
        check("wait_mod", mod_in, v);
    endtask

    task automatic check_hist(input string tag, input int vexp[$], input int hexp);
        check({tag, "_n"}, vals.size(), vexp.size());
        for (int i = 0; i < vexp.size() && i < vals.size(); i++) begin
            check($sformatf("%s_v%0d", tag, i), vals[i], vexp[i]);
            if (hexp > 0 && i > 0)
                check($sformatf("%s_h%0d", tag, i), holds[i], hexp);
        end
    endtask

    initial begin
        int c;
        int pairs;
        bit last;
        int seen7;
        int ev[$];

        // reset state
        #1 rst = 1'b1;
        #2;
        check("rst_mod_rst", mod_rst, 1);
        check("rst_mod_en", mod_en, 0);
        check("rst_mod_in", mod_in, 0);
        check("rst_ready", s_ready, 0);
        check("rst_ucnt", underflow_cnt, 0);
        check("rst_busy", busy, 0);
        cyc(2);
        rst = 1'b0;

        // cadence: three back-to-back samples
        cyc(2);
        mon_start();
        run = 1'b1;
        send(100);
        send(-200);
        send(300);
        s_valid = 1'b0;
        c = 0;
        pairs = 0;
        last = 0;
        repeat (16) begin
            cyc(1);
            if (mod_en) c++;
            if (mod_en && last) pairs++;
            last = mod_en;
        end
        check("cad_en_cnt", c, 8);
        check("cad_en_adj", pairs, 0);
        check("cad_mod_rst", mod_rst, 0);
        check("cad_busy", busy, 1);
        cyc(20);
        ev = '{0, 100, -200};
        check_hist("cad", ev, 8);
        if (pls.size() > 2)
            check("cad_pulses", pls[2], 4);
        check("cad_last", prev, 300);

        // underflow and saturation
        do_reset();
        run = 1'b1;
        send(500);
        s_valid = 1'b0;
        wait_mod(500);
        c = 0;
        repeat (32) begin
            cyc(1);
            if (underflow) c++;
        end
        check("uf_pulses", c, 4);
        check("uf_cnt4", underflow_cnt, 4);
        cyc(300 * 8);
        check("uf_sat", underflow_cnt, 255);
        check("uf_hold", mod_in, 500);

        // asynchronous reset mid-run
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_mod_rst", mod_rst, 1);
        check("arst_mod_en", mod_en, 0);
        check("arst_mod_in", mod_in, 0);
        check("arst_ready", s_ready, 0);
        check("arst_ucnt", underflow_cnt, 0);
        check("arst_busy", busy, 0);
        run = 1'b0;
        cyc(2);
        rst = 1'b0;

        // backpressure: 1..10 with valid held high
        cyc(2);
        mon_start();
        run = 1'b1;
        for (int i = 1; i <= 10; i++)
            send(W'(i));
        s_valid = 1'b0;
        cyc(12);
        ev = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        check_hist("bp", ev, 8);
        check("bp_last", prev, 10);

        // stop mid-period with 7 buffered
        do_reset();
        cyc(2);
        mon_start();
        run = 1'b1;
        send(5);
        send(7);
        s_valid = 1'b0;
        run = 1'b0;
        cyc(20);
        ev = '{0, 5};
        check_hist("stop", ev, 0);
        if (holds.size() > 1) begin
            check("stop_hold5", holds[1], 9);
            check("stop_pulses5", pls[1], 4);
        end
        seen7 = 0;
        foreach (vals[i])
            if (vals[i] == 7) seen7++;
        if (prev == 7) seen7++;
        check("stop_no7", seen7, 0);
        check("stop_mod_in", mod_in, 0);
        check("stop_mod_rst", mod_rst, 1);
        check("stop_busy", busy, 0);

`ifdef SD_STREAM_CTRL_RAMP_EN
        // fade-out from positive and negative values
        do_reset();
        run = 1'b1;
        send(1000);
        s_valid = 1'b0;
        wait_mod(1000);
        mon_start();
        run = 1'b0;
        cyc(120);
        ev = '{1000, 500, 250, 125, 62, 31, 15, 7, 3, 1};
        check_hist("rmp", ev, 8);
        check("rmp_end", prev, 0);
        check("rmp_busy", busy, 0);
        check("rmp_rst", mod_rst, 1);

        do_reset();
        run = 1'b1;
        send(-8);
        s_valid = 1'b0;
        wait_mod(-8);
        mon_start();
        run = 1'b0;
        cyc(60);
        ev = '{-8, -4, -2, -1};
        check_hist("rmn", ev, 8);
        check("rmn_end", prev, 0);
        check("rmn_busy", busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
